// File: rtl/npc_lsu.sv
// ============================================================================
// Module   : npc_lsu
// Brief    : Multi-cycle load/store unit issuing one aligned 8-byte beat per access.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module npc_lsu #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_op,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_we,
  output logic [XLEN-1:0] mem_req_addr,
  output logic [63:0]     mem_req_wdata,
  output logic [7:0]      mem_req_wmask,
  input  logic            mem_resp_valid,
  input  logic [63:0]     mem_resp_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  localparam int CW = $clog2(TIMEOUT) + 1;

  state_e          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            misaligned;
  logic [63:0]     ld_shift;
  logic [63:0]     ld_ext;
  logic [7:0]      size_mask;
  logic            in_req;
  logic            is_store;

  always_comb begin
    misaligned = 1'b0;
    case (req_op[1:0])
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      2'd3:    misaligned = |req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Bring the addressed byte lane down to bit 0, then extend by access size.
  assign ld_shift = mem_resp_rdata >> {addr_q[2:0], 3'b000};

  always_comb begin
    ld_ext = ld_shift;
    case (op_q[1:0])
      2'd0: ld_ext = op_q[2] ? {56'd0, ld_shift[7:0]}  : {{56{ld_shift[7]}},  ld_shift[7:0]};
      2'd1: ld_ext = op_q[2] ? {48'd0, ld_shift[15:0]} : {{48{ld_shift[15]}}, ld_shift[15:0]};
      2'd2: ld_ext = op_q[2] ? {32'd0, ld_shift[31:0]} : {{32{ld_shift[31]}}, ld_shift[31:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  always_comb begin
    size_mask = 8'h01;
    case (op_q[1:0])
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  assign in_req   = (state_q == S_REQ);
  assign is_store = op_q[3];

  assign req_ready     = (state_q == S_IDLE);
  assign resp_valid    = (state_q == S_RESP);
  assign resp_rdata    = rdata_q;
  assign resp_err      = err_q;
  assign mem_req_valid = in_req;
  assign mem_req_we    = in_req & is_store;
  assign mem_req_addr  = in_req ? {addr_q[XLEN-1:3], 3'b000} : '0;
  assign mem_req_wmask = (in_req && is_store) ? (size_mask << addr_q[2:0]) : 8'h00;
  assign mem_req_wdata = (in_req && is_store) ? (64'(wdata_q) << {addr_q[2:0], 3'b000}) : 64'd0;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = misaligned;
          state_d = misaligned ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A response in the timeout cycle still completes normally.
        if (mem_resp_valid) begin
          state_d = S_RESP;
          err_d   = 1'b0;
          rdata_d = is_store ? '0 : XLEN'(ld_ext);
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

`default_nettype wire
